// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word access to an internal data RAM with a
// fixed number of wait states, stalling upstream while the access is in
// flight, and registering results into the MEM/WB outputs.
module mem_stage #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB,
  input  logic [1:0]  Mem,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemWriteData,
  input  logic [4:0]  rdAddr,
  output logic        stall,
  output logic [1:0]  WB_out,
  output logic [31:0] ReadData_wb,
  output logic [31:0] ALUResult_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        misalign
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        mis_q, mis_d;

  logic [31:0] ram_q [Depth];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  mem_any;
  logic                  aligned;
  logic                  complete;
  logic                  ram_we;
  logic [31:0]           ram_rdata;

  // Upper address bits are ignored so the index wraps around the RAM.
  assign idx       = ALUResult[DEPTH_LOG2+1:2];
  assign mem_any   = (Mem != 2'b00);
  assign aligned   = (ALUResult[1:0] == 2'b00);
  assign ram_rdata = ram_q[idx];
  // Reset on the completing edge aborts the store.
  assign ram_we    = complete && Mem[0] && !reset;

  // Next-state, stall and MEM/WB next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    wb_d     = WB;
    alu_d    = ALUResult;
    rd_d     = rdAddr;
    rdata_d  = 32'h0;
    mis_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_any && !aligned) begin
          // Squash write-back, still pass address and destination through.
          wb_d  = 2'b00;
          mis_d = 1'b1;
        end else if (mem_any) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // While stalled the MEM/WB register receives a bubble.
    if (stall) begin
      wb_d  = 2'b00;
      alu_d = 32'h0;
      rd_d  = 5'd0;
    end
    // Combinational read gives pre-write contents when read and write coincide.
    if (complete && Mem[1]) rdata_d = ram_rdata;
  end

  // FSM and MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wb_q    <= 2'b00;
      rdata_q <= 32'h0;
      alu_q   <= 32'h0;
      rd_q    <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= MemWriteData;
  end

  assign WB_out       = wb_q;
  assign ReadData_wb  = rdata_q;
  assign ALUResult_wb = alu_q;
  assign rdAddr_wb    = rd_q;
  assign misalign     = mis_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, sitting directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result (address), store data, memory control, write-back control and destination register. It performs a word access to an internal data RAM with a configurable number of wait states, stalling upstream while the access is in flight, and registers the result into the MEM/WB outputs.

## Interface
- DEPTH_LOG2, 8: log2 of RAM depth in 32-bit words; word index = ALUResult[DEPTH_LOG2+1:2], upper address bits ignored (wrap).
- WAIT_STATES, 2: extra cycles per memory access, legal range 0..15.

- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high.
- WB  in  2  write-back control from EX/MEM; bit0 RegWrite, bit1 MemtoReg.
- Mem  in  2  memory control from EX/MEM; bit0 MemWrite, bit1 MemRead.
- ALUResult  in  32  byte address / ALU result.
- MemWriteData  in  32  store data.
- rdAddr  in  5  destination register.
- stall  out  1  combinational; 1 = upstream (EX/MEM and earlier) must hold its outputs.
- WB_out  out  2  registered MEM/WB write-back control.
- ReadData_wb  out  32  registered load data.
- ALUResult_wb  out  32  registered ALU result.
- rdAddr_wb  out  5  registered destination register.
- misalign  out  1  registered one-cycle pulse on a misaligned access.

## Operation
- "access" = Mem != 0 and ALUResult[1:0] == 0. "misaligned" = Mem != 0 and ALUResult[1:0] != 0.
- FSM states: IDLE, BUSY; 4-bit down-counter cnt.
- IDLE, no Mem: MEM/WB loads WB, ALUResult, rdAddr; ReadData_wb <= 0; stall = 0.
- IDLE, misaligned: no RAM access, no stall; MEM/WB loads WB_out <= 0 (squashed), ALUResult_wb/rdAddr_wb loaded normally, ReadData_wb <= 0; misalign <= 1 for one cycle.
- IDLE, access, WAIT_STATES == 0: access completes at this edge, no stall (see completion rules).
- IDLE, access, WAIT_STATES > 0: stall = 1; cnt <= WAIT_STATES-1; -> BUSY; MEM/WB loads a bubble (all fields 0).
- BUSY, cnt != 0: stall = 1; cnt <= cnt-1; MEM/WB loads bubble; inputs are held stable by upstream.
- BUSY, cnt == 0: stall = 0; access completes at this edge; -> IDLE.
- Completion: Mem[0] writes MemWriteData to RAM[index]. If Mem[1], ReadData_wb <= RAM[index] (pre-write contents if both bits set, i.e. read-before-write), else 0. WB_out, ALUResult_wb and rdAddr_wb are loaded from the inputs.
- Mem == 2'b11 is not emitted by decode; the behaviour above is still mandatory.
- RAM contents are not cleared by reset.

## Timing
- Reset: WB_out, ReadData_wb, ALUResult_wb, rdAddr_wb = 0; misalign = 0; state IDLE; cnt = 0; stall = 0 the cycle after reset.
- Reset during BUSY aborts the access: no RAM write occurs, and outputs clear at that edge.
- Non-memory and misaligned instructions: 1-cycle latency, no stall.
- Memory access: stall is high for exactly WAIT_STATES cycles, starting the cycle the access is first presented. Results appear in MEM/WB WAIT_STATES+1 edges after first presentation.
- Back-to-back accesses each pay the full wait; no overlap.
- A new access is sampled in IDLE in the same cycle it completes the previous one only after upstream releases; there is no dead cycle between accesses.
- misalign pulses on the edge the misaligned instruction is registered, and is 0 otherwise.

## Test plan
- Reset then idle: reset=1 for 2 cycles -> all outputs 0, stall 0; Mem=0, WB=2'b01, ALUResult=0x1234, rdAddr=5 -> next edge WB_out=01, ALUResult_wb=0x1234, rdAddr_wb=5, ReadData_wb=0.
- Store/load, WAIT_STATES=2: store 0xDEADBEEF to addr 0x10 -> stall high 2 cycles, bubbles in MEM/WB. Then load addr 0x10 with WB=2'b11, rdAddr=9 -> after 3 edges ReadData_wb=0xDEADBEEF, WB_out=11, rdAddr_wb=9.
- Misaligned: Mem=2'b10, ALUResult=0x13, WB=2'b11 -> no stall, WB_out=00, misalign=1 for one cycle. A later aligned read of 0x10 returns unchanged data.
- Wrap: DEPTH_LOG2=8, store 0x55 to 0x400 -> a load from 0x000 returns 0x55.
- Read-before-write: RAM[0x20]=0xA, Mem=2'b11, data 0xB -> ReadData_wb=0xA; a subsequent load from 0x20 returns 0xB.
- Reset mid-access: store 0x77 to 0x30, assert reset in the second stall cycle -> outputs 0, state IDLE, and a later load from 0x30 returns the old value.
